// File: rtl/spi_burst_if.sv
// Host-side command/TX/RX streams plus the SPI engine register port of spi_burst.
// Every *_valid/*_ready pair: a beat transfers on a posedge where both are high; the source holds data stable while valid.
interface spi_burst_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_sel;
   logic [7:0] cmd_len;
   logic       cmd_discard;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic [2:0] spi_addr;
   logic [7:0] spi_wdata;
   logic [7:0] spi_rdata;
   logic [1:0] spi_sel;
   logic       spi_read;
   logic       spi_write;
   logic       spi_irq;

   modport slave (
      input  cmd_valid, cmd_sel, cmd_len, cmd_discard, tx_valid, tx_data, rx_ready,
             spi_rdata, spi_irq,
      output cmd_ready, tx_ready, rx_valid, rx_data, busy, done, spi_addr, spi_wdata,
             spi_sel, spi_read, spi_write
   );

   modport master (
      output cmd_valid, cmd_sel, cmd_len, cmd_discard, tx_valid, tx_data, rx_ready,
             spi_rdata, spi_irq,
      input  cmd_ready, tx_ready, rx_valid, rx_data, busy, done, spi_addr, spi_wdata,
             spi_sel, spi_read, spi_write
   );
endinterface

// File: rtl/spi_burst.sv
// Burst sequencer driving an SPI engine register port: one write/irq/read round per byte.
// Define SPI_BURST_RXFIFO_EN for a 2**RXD_LOG2-entry RX FIFO; otherwise RX is a single holding register.
module spi_burst #(
   parameter int RXD_LOG2 = 2
) (
   input  logic       clk,
   input  logic       reset,
   spi_burst_if.slave bus,
   output logic [2:0] dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;

   logic [2:0] state;
   logic [1:0] sel_q;
   logic [7:0] remain;
   logic       discard_q;
   logic       last;
   logic       do_write;
   logic       do_read;
   logic       rx_space;
   logic       push;
   logic       pop;

   assign last     = (remain == 8'd0);
   assign do_write = ((state == S_START) || (state == S_NEXT)) && bus.tx_valid;
   assign do_read  = (state == S_READ) && (discard_q || rx_space);
   assign push     = do_read && !discard_q;
   assign pop      = bus.rx_valid && bus.rx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         sel_q     <= 2'd0;
         remain    <= 8'd0;
         discard_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  sel_q     <= bus.cmd_sel;
                  remain    <= bus.cmd_len;
                  discard_q <= bus.cmd_discard;
                  state     <= S_START;
               end
            end
            S_START: if (do_write) state <= S_WAIT;
            S_WAIT:  if (bus.spi_irq) state <= S_READ;
            S_READ: begin
               if (do_read) begin
                  // The addr-0 read on the final byte makes the engine release CS.
                  if (last) begin
                     state <= S_IDLE;
                  end else begin
                     remain <= remain - 8'd1;
                     state  <= S_NEXT;
                  end
               end
            end
            S_NEXT:  if (do_write) state <= S_WAIT;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.spi_addr = 3'd0;
      if (do_write) begin
         bus.spi_addr = {2'b00, (state == S_NEXT)};
      end else if (do_read) begin
         bus.spi_addr = {2'b00, !last};
      end
   end

   assign bus.cmd_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = do_read && last;
   assign bus.tx_ready  = do_write;
   assign bus.spi_write = do_write;
   assign bus.spi_read  = do_read;
   assign bus.spi_wdata = do_write ? bus.tx_data : 8'h00;
   assign bus.spi_sel   = (state != S_IDLE) ? sel_q : 2'd0;
   assign dbg_state     = state;

`ifdef SPI_BURST_RXFIFO_EN
   localparam int DEPTH = 1 << RXD_LOG2;

   logic [7:0]        mem [DEPTH];
   logic [RXD_LOG2:0] wr_ptr;
   logic [RXD_LOG2:0] rd_ptr;
   logic              full;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign full = (wr_ptr[RXD_LOG2] != rd_ptr[RXD_LOG2]) &&
                 (wr_ptr[RXD_LOG2-1:0] == rd_ptr[RXD_LOG2-1:0]);
   assign rx_space    = !full || bus.rx_ready;
   assign bus.rx_valid = (wr_ptr != rd_ptr);
   assign bus.rx_data  = mem[rd_ptr[RXD_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[RXD_LOG2-1:0]] <= bus.spi_rdata;
   end
`else
   logic       hold_valid;
   logic [7:0] hold_data;
   logic       unused_cfg;

   assign unused_cfg   = RXD_LOG2[0];
   assign rx_space     = !hold_valid || bus.rx_ready;
   assign bus.rx_valid = hold_valid;
   assign bus.rx_data  = hold_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= 8'h00;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= bus.spi_rdata;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_spi_burst.sv
// Randomized bench for spi_burst: a bus-functional SPI engine plus a per-command model of expected writes, reads and RX bytes.
module tb_spi_burst;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_READ = 3'd3;
   localparam logic [2:0] ST_NEXT = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] dbg_state;

   spi_burst_if bus ();

   spi_burst #(.RXD_LOG2(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_err = 0;
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic [2:0] exp_wr_addr[$];
   logic [2:0] exp_rd_addr[$];
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         done_cnt = 0;
   int         rx_seen = 0;
   int         irq_cnt = 0;
   int         rx_mode = 1;
   bit         mon_en = 1'b0;
   bit         cur_discard = 1'b0;
   logic [1:0] cur_sel = 2'd0;
   bit         tx_hold = 1'b0;
   bit         hold_on_write = 1'b0;
   bit         force_rdata = 1'b0;
   logic [7:0] rdata_val = 8'h00;
   logic [7:0] last_rx = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Engine and stream drivers: inputs change 1 time unit after each posedge.
   initial begin
      bus.spi_irq   = 1'b0;
      bus.spi_rdata = 8'h00;
      bus.tx_valid  = 1'b0;
      bus.tx_data   = 8'h00;
      bus.rx_ready  = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.spi_irq = 1'b0;
         if (irq_cnt > 0) begin
            irq_cnt--;
            if (irq_cnt == 0) bus.spi_irq = 1'b1;
         end
         bus.spi_rdata = force_rdata ? rdata_val : 8'($urandom);
         bus.rx_ready  = (rx_mode == 0) ? 1'($urandom) : (rx_mode == 1);
         if (tx_q.size() > 0 && !tx_hold && $urandom_range(0, 3) != 0) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = tx_q[0];
         end else begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
         end
      end
   end

   // Scoreboard: samples mid-cycle, consumes the expected queues.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("rw_exclusive", 32'(bus.spi_read && bus.spi_write), 0);
         check("tx_ready_eq_write", 32'(bus.tx_ready), 32'(bus.spi_write));
         check("busy_not_cmd_ready", 32'(bus.busy), 32'(!bus.cmd_ready));
         check("spi_sel", 32'(bus.spi_sel), bus.busy ? 32'(cur_sel) : 0);
         if (bus.spi_write) begin
            wr_cnt++;
            if (exp_wr_addr.size() == 0 || tx_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               check("wr_addr", 32'(bus.spi_addr), 32'(exp_wr_addr.pop_front()));
               check("wr_data", 32'(bus.spi_wdata), 32'(tx_q.pop_front()));
            end
            irq_cnt = $urandom_range(1, 4);
            if (hold_on_write) begin
               tx_hold = 1'b1;
               hold_on_write = 1'b0;
            end
         end
         if (bus.spi_read) begin
            rd_cnt++;
            if (exp_rd_addr.size() == 0) check("unexpected_read", 1, 0);
            else check("rd_addr", 32'(bus.spi_addr), 32'(exp_rd_addr.pop_front()));
            if (!cur_discard) exp_q.push_back(bus.spi_rdata);
         end
         if (bus.rx_valid) rx_seen++;
         if (bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rx", 1, 0);
            end else begin
               last_rx = bus.rx_data;
               check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
         end
         if (bus.done) done_cnt++;
      end
   end

   task automatic push_tx(input logic [7:0] len, input bit counting);
      for (int i = 0; i <= int'(len); i++) tx_q.push_back(counting ? 8'(i + 1) : 8'($urandom));
   endtask

   task automatic run_cmd(input logic [1:0] sel, input logic [7:0] len, input bit disc);
      cur_sel = sel;
      cur_discard = disc;
      wr_cnt = 0;
      rd_cnt = 0;
      rx_seen = 0;
      for (int i = 0; i <= int'(len); i++) exp_wr_addr.push_back((i == 0) ? 3'd0 : 3'd1);
      for (int i = 0; i <= int'(len); i++) exp_rd_addr.push_back((i == int'(len)) ? 3'd0 : 3'd1);
      @(posedge clk); #1;
      bus.cmd_valid   = 1'b1;
      bus.cmd_sel     = sel;
      bus.cmd_len     = len;
      bus.cmd_discard = disc;
      @(negedge clk);
      check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
      @(posedge clk); #1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_sel     = 2'($urandom);
      bus.cmd_len     = 8'($urandom);
      bus.cmd_discard = 1'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != start), 1);
   endtask

   task automatic finish_cmd(input string tag, input logic [7:0] len);
      check({tag, "_writes"}, wr_cnt, int'(len) + 1);
      check({tag, "_reads"}, rd_cnt, int'(len) + 1);
      check({tag, "_wr_left"}, exp_wr_addr.size(), 0);
      check({tag, "_rd_left"}, exp_rd_addr.size(), 0);
      @(negedge clk); #1;
      check({tag, "_busy_fell"}, 32'(bus.busy), 0);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_tx_ready"}, 32'(bus.tx_ready), 0);
      check({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
      check({tag, "_spi_read"}, 32'(bus.spi_read), 0);
      check({tag, "_spi_write"}, 32'(bus.spi_write), 0);
      check({tag, "_spi_addr"}, 32'(bus.spi_addr), 0);
      check({tag, "_spi_sel"}, 32'(bus.spi_sel), 0);
      check({tag, "_spi_wdata"}, 32'(bus.spi_wdata), 0);
      check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      int n;
      int d0;
      logic [7:0] len;
      bus.cmd_valid   = 1'b0;
      bus.cmd_sel     = 2'd0;
      bus.cmd_len     = 8'd0;
      bus.cmd_discard = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      #1 reset = 1'b0;
      mon_en = 1'b1;

      // Single byte: A5 out, 3C back.
      force_rdata = 1'b1;
      rdata_val = 8'h3C;
      rx_mode = 1;
      tx_q.push_back(8'hA5);
      run_cmd(2'd1, 8'd0, 1'b0);
      wait_done("single", 100);
      finish_cmd("single", 8'd0);
      drain("single", 50);
      check("single_rx_byte", 32'(last_rx), 32'h3C);
      force_rdata = 1'b0;

      // Four-byte burst with counting TX data.
      push_tx(8'd3, 1'b1);
      run_cmd(2'd0, 8'd3, 1'b0);
      wait_done("burst4", 300);
      finish_cmd("burst4", 8'd3);
      drain("burst4", 50);

      // RX consumer stalled for a whole four-byte burst.
      rx_mode = 2;
      push_tx(8'd3, 1'b0);
      run_cmd(2'd2, 8'd3, 1'b0);
`ifdef SPI_BURST_RXFIFO_EN
      wait_done("rxfull", 300);
      check("rxfull_reads", rd_cnt, 4);
      check("rxfull_buffered", exp_q.size(), 4);
      check("rxfull_rx_valid", 32'(bus.rx_valid), 1);
      rx_mode = 1;
      finish_cmd("rxfull", 8'd3);
      drain("rxfull", 50);
`else
      d0 = done_cnt;
      repeat (80) @(negedge clk);
      #1;
      check("rxstall_no_done", done_cnt, d0);
      check("rxstall_reads", rd_cnt, 1);
      check("rxstall_state", 32'(dbg_state), 32'(ST_READ));
      check("rxstall_no_read", 32'(bus.spi_read), 0);
      check("rxstall_rx_valid", 32'(bus.rx_valid), 1);
      rx_mode = 1;
      wait_done("rxstall", 300);
      finish_cmd("rxstall", 8'd3);
      drain("rxstall", 50);
`endif

      // TX starvation for 20 cycles while in NEXT.
      hold_on_write = 1'b1;
      push_tx(8'd2, 1'b0);
      run_cmd(2'd2, 8'd2, 1'b0);
      n = 0;
      while (dbg_state != ST_NEXT && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("txgap_reached_next", 32'(dbg_state), 32'(ST_NEXT));
      d0 = wr_cnt;
      repeat (20) @(negedge clk);
      #1;
      check("txgap_no_write", wr_cnt, d0);
      check("txgap_state", 32'(dbg_state), 32'(ST_NEXT));
      check("txgap_sel_held", 32'(bus.spi_sel), 2);
      tx_hold = 1'b0;
      wait_done("txgap", 300);
      finish_cmd("txgap", 8'd2);
      drain("txgap", 50);

      // Discard: reads happen, nothing reaches the RX stream.
      push_tx(8'd2, 1'b0);
      run_cmd(2'd3, 8'd2, 1'b1);
      wait_done("discard", 300);
      finish_cmd("discard", 8'd2);
      check("discard_no_rx_valid", rx_seen, 0);

      // Reset while waiting for the engine, with RX data held.
      rx_mode = 2;
      push_tx(8'd3, 1'b0);
      run_cmd(2'd1, 8'd3, 1'b0);
      n = 0;
      while (!(rd_cnt >= 1 && dbg_state == ST_WAIT) && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check("rstwait_in_wait", 32'(dbg_state), 32'(ST_WAIT));
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("rstwait");
      #1;
      tx_q.delete();
      exp_q.delete();
      exp_wr_addr.delete();
      exp_rd_addr.delete();
      irq_cnt = 0;
      rx_mode = 1;
      reset = 1'b0;
      @(negedge clk);
      check("rstwait_rx_empty_after", 32'(bus.rx_valid), 0);
      #1;

      // Long burst exercising the full 8-bit remain counter.
      rx_mode = 0;
      push_tx(8'd255, 1'b0);
      run_cmd(2'd0, 8'd255, 1'b1);
      wait_done("len255", 8000);
      finish_cmd("len255", 8'd255);

      // Random commands with random TX gaps and RX backpressure.
      for (int k = 0; k < 20; k++) begin
         len = 8'($urandom_range(0, 7));
         push_tx(len, 1'b0);
         run_cmd(2'($urandom), len, 1'($urandom_range(0, 3) == 0));
         wait_done("rand", 600);
         finish_cmd("rand", len);
         drain("rand", 300);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_burst.md
SPI_BURST -- requirements
Module: spi_burst

Interface
REQ-001 SHALL have parameter: RXD_LOG2, 2, log2 of RX FIFO depth (used only when SPI_BURST_RXFIFO_EN is defined).
REQ-002 SHALL have ports: clk  in  1  sole clock; all state on posedge.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: cmd_valid/cmd_ready  in/out  1/1  transfer command handshake.
REQ-005 SHALL have: cmd_sel  in  2  SPI select (0-2 chip selects, 3 = no CS); cmd_len  in  8  byte count minus 1; cmd_discard  in  1  drop received bytes.
REQ-006 SHALL have: tx_valid/tx_ready/tx_data  in/out/in  1/1/8  transmit byte stream.
REQ-007 SHALL have: rx_valid/rx_ready/rx_data  out/in/out  1/1/8  receive byte stream.
REQ-008 SHALL have: busy  out  1  command in progress; done  out  1  one-cycle end-of-command pulse.
REQ-009 SHALL have: spi_addr  out  3; spi_wdata  out  8; spi_rdata  in  8; spi_sel  out  2; spi_read  out  1; spi_write  out  1; spi_irq  in  1 -- SPI engine register port.

Function
REQ-010 SHALL implement states IDLE, START, WAIT, READ, NEXT.
REQ-011 IDLE: cmd_ready=1; on cmd_valid, latch sel/len/discard into remain counter, go START.
REQ-012 START: when tx_valid, assert spi_write=1, spi_addr=0, spi_wdata=tx_data, tx_ready=1 for exactly that cycle; go WAIT.
REQ-013 WAIT: spi_read/spi_write low; on spi_irq=1 go READ; no timeout.
REQ-014 READ: when RX storage has space (or discard=1), assert spi_read=1 for one cycle with spi_addr=0 if remain==0 else 1; capture spi_rdata same cycle; push to RX storage unless discard.
REQ-015 READ with remain==0: go IDLE, pulse done (engine releases CS on addr-0 read).
REQ-016 READ with remain!=0: decrement remain, go NEXT.
REQ-017 NEXT: when tx_valid, spi_write=1, spi_addr=1, spi_wdata=tx_data, tx_ready=1 one cycle; go WAIT; while tx_valid=0 hold (CS stays asserted).
REQ-018 spi_sel SHALL equal latched cmd_sel whenever busy; 0 in IDLE.
REQ-019 At most one of spi_read/spi_write high per cycle; tx_ready high only when spi_write high.
REQ-020 busy = state!=IDLE; cmd_ready = state==IDLE.
REQ-021 cmd_len=0 SHALL perform exactly one write (addr 0) and one read (addr 0).
REQ-022 RX full in READ: stall with spi_read=0 until space; push and pop in same cycle when full SHALL be allowed.
REQ-023 rx_data SHALL be FIFO head, rx_valid = not empty; ordering preserved.
REQ-024 remain is 8-bit; no wrap: decremented only when nonzero.

Reset
REQ-025 On reset: state IDLE, remain 0, RX storage empty; outputs cmd_ready=1, busy=0, done=0, tx_ready=0, rx_valid=0, spi_read=0, spi_write=0, spi_addr=0, spi_sel=0, spi_wdata=0.
REQ-026 Reset mid-transfer SHALL abort immediately, discarding RX contents; engine shares same reset.

Configuration
REQ-027 Macro SPI_BURST_RXFIFO_EN defined: RX storage is a 2**RXD_LOG2-entry FIFO.
REQ-028 Macro undefined: RX storage is a single-entry holding register; READ stalls whenever it is occupied and not popped that cycle.

Verification
REQ-029 cmd sel=1 len=0, tx A5, engine model returns 3C -> write addr0 A5, read addr0, rx 3C, done pulse, busy falls.
REQ-030 cmd len=3, tx 01..04 -> writes addr0,1,1,1; reads addr1,1,1,0; rx four bytes in order.
REQ-031 len=3, rx_ready=0 with FIFO enabled depth 4 -> all 4 bytes buffered, done; without macro -> stalls in READ after byte 1.
REQ-032 tx_valid dropped 20 cycles in NEXT -> no spi_write, spi_sel held, transfer resumes and completes.
REQ-033 cmd_discard=1 len=2 -> rx_valid never asserts, three reads still issued.
REQ-034 reset asserted in WAIT -> next cycle IDLE, all outputs at reset values, rx_valid=0.
